// File: rtl/pcs_transmit.sv
// pcs_transmit: GMII transmit octets to 8b/10b code-groups.
// Generates ordered sets for idle, start, terminate and carrier extend, and tracks running disparity.
module pcs_transmit (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       TX_EN,
    input  logic       TX_ER,
    input  logic [7:0] TXD,
    output logic [9:0] tx_code_group,
    output logic       tx_even,
    output logic       tx_rd
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        END_T  = 3'd3,
        END_R1 = 3'd4,
        END_R2 = 3'd5
    } state_t;

    localparam logic [7:0] K28_5 = 8'hBC;
    localparam logic [7:0] K27_7 = 8'hFB;
    localparam logic [7:0] K29_7 = 8'hFD;
    localparam logic [7:0] K30_7 = 8'hFE;
    localparam logic [7:0] K23_7 = 8'hF7;
    localparam logic [7:0] D5_6  = 8'hC5;
    localparam logic [7:0] D16_2 = 8'h50;

    state_t     state;
    logic       even_slot;
    logic       sym_k;
    logic [7:0] sym_octet;
    logic [4:0] x5;
    logic [2:0] y3;
    logic [5:0] six;
    logic [5:0] six_out;
    logic [3:0] four;
    logic [3:0] four_out;
    logic       six_neutral;
    logic       four_neutral;
    logic       rd_mid;
    logic       use_a7;
    logic       enc_rd;
    logic [9:0] enc_code;

    // abcdei sub-block as listed for negative running disparity
    function automatic logic [5:0] abcdei_neg(input logic [4:0] x);
        case (x)
            5'd0:  abcdei_neg = 6'b100111;
            5'd1:  abcdei_neg = 6'b011101;
            5'd2:  abcdei_neg = 6'b101101;
            5'd3:  abcdei_neg = 6'b110001;
            5'd4:  abcdei_neg = 6'b110101;
            5'd5:  abcdei_neg = 6'b101001;
            5'd6:  abcdei_neg = 6'b011001;
            5'd7:  abcdei_neg = 6'b111000;
            5'd8:  abcdei_neg = 6'b111001;
            5'd9:  abcdei_neg = 6'b100101;
            5'd10: abcdei_neg = 6'b010101;
            5'd11: abcdei_neg = 6'b110100;
            5'd12: abcdei_neg = 6'b001101;
            5'd13: abcdei_neg = 6'b101100;
            5'd14: abcdei_neg = 6'b011100;
            5'd15: abcdei_neg = 6'b010111;
            5'd16: abcdei_neg = 6'b011011;
            5'd17: abcdei_neg = 6'b100011;
            5'd18: abcdei_neg = 6'b010011;
            5'd19: abcdei_neg = 6'b110010;
            5'd20: abcdei_neg = 6'b001011;
            5'd21: abcdei_neg = 6'b101010;
            5'd22: abcdei_neg = 6'b011010;
            5'd23: abcdei_neg = 6'b111010;
            5'd24: abcdei_neg = 6'b110011;
            5'd25: abcdei_neg = 6'b100110;
            5'd26: abcdei_neg = 6'b010110;
            5'd27: abcdei_neg = 6'b110110;
            5'd28: abcdei_neg = 6'b001110;
            5'd29: abcdei_neg = 6'b101110;
            5'd30: abcdei_neg = 6'b011110;
            default: abcdei_neg = 6'b101011;
        endcase
    endfunction

    // Slot of the code-group produced at the coming edge
    assign even_slot = ~tx_even;

    // Pick the octet/control symbol for the coming slot
    always_comb begin
        sym_k     = 1'b1;
        sym_octet = K28_5;
        case (state)
            IDLE: begin
                if (even_slot) begin
                    if (TX_EN) sym_octet = K27_7;
                end else begin
                    sym_k     = 1'b0;
                    sym_octet = tx_rd ? D16_2 : D5_6;
                end
            end
            START: sym_octet = K27_7;
            DATA: begin
                if (!TX_EN) begin
                    sym_octet = K29_7;
                end else if (TX_ER) begin
                    sym_octet = K30_7;
                end else begin
                    sym_k     = 1'b0;
                    sym_octet = TXD;
                end
            end
            END_T:   sym_octet = K29_7;
            END_R1:  sym_octet = K23_7;
            END_R2:  sym_octet = K23_7;
            default: sym_octet = K28_5;
        endcase
    end

    // 8b/10b encode of the selected symbol against current running disparity
    always_comb begin
        x5          = sym_octet[4:0];
        y3          = sym_octet[7:5];
        six         = (sym_k && (x5 == 5'd28)) ? 6'b001111 : abcdei_neg(x5);
        six_neutral = ($countones(six) == 3);
        six_out     = (tx_rd && (!six_neutral || (six == 6'b111000))) ? ~six : six;
        rd_mid      = six_neutral ? tx_rd : ~tx_rd;
        use_a7      = rd_mid ? ((x5 == 5'd11) || (x5 == 5'd13) || (x5 == 5'd14))
                             : ((x5 == 5'd17) || (x5 == 5'd18) || (x5 == 5'd20));
        four        = 4'b1011;
        if (sym_k) begin
            four = (y3 == 3'd5) ? 4'b0101 : 4'b0111;
        end else begin
            case (y3)
                3'd0:    four = 4'b1011;
                3'd1:    four = 4'b1001;
                3'd2:    four = 4'b0101;
                3'd3:    four = 4'b1100;
                3'd4:    four = 4'b1101;
                3'd5:    four = 4'b1010;
                3'd6:    four = 4'b0110;
                default: four = use_a7 ? 4'b0111 : 4'b1110;
            endcase
        end
        four_neutral = ($countones(four) == 2);
        four_out     = (rd_mid && (!four_neutral || sym_k || (four == 4'b1100))) ? ~four : four;
        enc_rd       = four_neutral ? rd_mid : ~rd_mid;
        enc_code     = {six_out, four_out};
    end

    // Ordered-set state machine and registered code-group outputs
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state         <= IDLE;
            tx_code_group <= 10'b0;
            tx_even       <= 1'b0;
            tx_rd         <= 1'b0;
        end else begin
            tx_code_group <= enc_code;
            tx_rd         <= enc_rd;
            tx_even       <= even_slot;
            case (state)
                IDLE:    if (TX_EN) state <= even_slot ? DATA : START;
                START:   state <= DATA;
                DATA:    if (!TX_EN) state <= END_R1;
                END_T:   state <= END_R1;
                END_R1:  state <= even_slot ? END_R2 : IDLE;
                END_R2:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pcs_transmit.sv
// tb_pcs_transmit: directed literal checks plus randomized traffic against a behavioural model.
module tb_pcs_transmit;
    logic       Clk = 1'b0;
    logic       Reset;
    logic       TX_EN;
    logic       TX_ER;
    logic [7:0] TXD;
    logic [9:0] tx_code_group;
    logic       tx_even;
    logic       tx_rd;

    int n_cmp  = 0;
    int n_fail = 0;
    logic cmp_en = 1'b0;

    // Model state
    logic [9:0] exp_code = 10'b0;
    logic       exp_even = 1'b0;
    logic       exp_rd   = 1'b0;
    logic       m_in_data = 1'b0;
    logic       m_pending = 1'b0;
    int         m_r_left  = 0;

    localparam logic [5:0] T6 [32] = '{
        6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
        6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
        6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
        6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
    localparam logic [3:0] T4 [8] = '{
        4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};

    pcs_transmit dut (
        .Clk(Clk), .Reset(Reset), .TX_EN(TX_EN), .TX_ER(TX_ER), .TXD(TXD),
        .tx_code_group(tx_code_group), .tx_even(tx_even), .tx_rd(tx_rd)
    );

    always #5 Clk = ~Clk;

    // Encode one symbol from disparity arithmetic and the run-length rule
    function automatic void enc(input logic k, input logic [7:0] b, input logic rd_in,
                                output logic [9:0] code, output logic rd_out);
        logic [5:0] s;
        logic [3:0] f;
        logic       rd;
        int         d;
        s = (k && (b[4:0] == 5'd28)) ? 6'b001111 : T6[b[4:0]];
        d = 2 * $countones(s) - 6;
        if (rd_in && (d > 0 || s == 6'b111000)) s = ~s;
        d = 2 * $countones(s) - 6;
        if (d > 0) rd = 1'b1;
        else if (d < 0) rd = 1'b0;
        else if (s == 6'b000111) rd = 1'b1;
        else if (s == 6'b111000) rd = 1'b0;
        else rd = rd_in;
        if (k) f = (b[7:5] == 3'd5) ? 4'b0101 : 4'b0111;
        else f = T4[b[7:5]];
        d = 2 * $countones(f) - 4;
        if (rd && (d > 0 || f == 4'b1100 || (k && f == 4'b0101))) f = ~f;
        if (!k && b[7:5] == 3'd7 && s[1] == s[0] && f[3] == s[0] && f[2] == s[0] && f[1] == s[0])
            f = rd ? 4'b1000 : 4'b0111;
        d = 2 * $countones(f) - 4;
        if (d > 0) rd_out = 1'b1;
        else if (d < 0) rd_out = 1'b0;
        else if (f == 4'b0011) rd_out = 1'b1;
        else if (f == 4'b1100) rd_out = 1'b0;
        else rd_out = rd;
        code = {s, f};
    endfunction

    task automatic model_step();
        logic       slot_even;
        logic       k;
        logic [7:0] b;
        logic [9:0] c;
        logic       r;
        slot_even = !exp_even;
        k = 1'b1;
        b = 8'hBC;
        if (m_r_left > 0) begin
            b = 8'hF7;
            m_r_left--;
        end else if (m_in_data) begin
            if (TX_EN) begin
                if (TX_ER) b = 8'hFE;
                else begin k = 1'b0; b = TXD; end
            end else begin
                b = 8'hFD;
                m_in_data = 1'b0;
                m_r_left = slot_even ? 1 : 2;
            end
        end else if (m_pending) begin
            b = 8'hFB;
            m_pending = 1'b0;
            m_in_data = 1'b1;
        end else if (slot_even) begin
            if (TX_EN) begin b = 8'hFB; m_in_data = 1'b1; end
        end else begin
            k = 1'b0;
            b = exp_rd ? 8'h50 : 8'hC5;
            if (TX_EN) m_pending = 1'b1;
        end
        enc(k, b, exp_rd, c, r);
        exp_code = c;
        exp_rd   = r;
        exp_even = slot_even;
    endtask

    task automatic model_reset();
        exp_code  = 10'b0;
        exp_even  = 1'b0;
        exp_rd    = 1'b0;
        m_in_data = 1'b0;
        m_pending = 1'b0;
        m_r_left  = 0;
    endtask

    task automatic chk(input string name, input logic [9:0] act, input logic [9:0] want);
        n_cmp++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %b want %b at %0t", name, act, want, $time);
        end
    endtask

    task automatic drive(input logic en, input logic er, input logic [7:0] d);
        TX_EN = en;
        TX_ER = er;
        TXD   = d;
        @(negedge Clk);
    endtask

    task automatic lit(input string name, input logic [9:0] code, input logic ev, input logic rd);
        chk({name, "_code"}, tx_code_group, code);
        chk({name, "_even"}, 10'(tx_even), 10'(ev));
        chk({name, "_rd"}, 10'(tx_rd), 10'(rd));
    endtask

    // Reference model advances on the same edges as the design
    initial begin
        forever begin
            @(posedge Clk or negedge Reset);
            if (!Reset) model_reset();
            else model_step();
        end
    end

    // Every-cycle comparison against the model
    initial begin
        forever begin
            @(negedge Clk);
            if (cmp_en) begin
                chk("model_code", tx_code_group, exp_code);
                chk("model_even", 10'(tx_even), 10'(exp_even));
                chk("model_rd", 10'(tx_rd), 10'(exp_rd));
            end
        end
    end

    initial begin
        logic en;
        Reset = 1'b1; TX_EN = 1'b0; TX_ER = 1'b0; TXD = 8'h00;
        #1 Reset = 1'b0;
        @(negedge Clk);
        cmp_en = 1'b1;
        @(negedge Clk);
        lit("reset", 10'b0000000000, 1'b0, 1'b0);
        #2 Reset = 1'b1;

        // Idle after release
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 8'($urandom));
            if (i % 2 == 0) lit("idle_k", 10'b0011111010, 1'b1, 1'b1);
            else            lit("idle_i2", 10'b1001000101, 1'b0, 1'b0);
        end

        // Packet starting on even slot, ending with /T/ even
        drive(1'b1, 1'b0, 8'h55); lit("s_even", 10'b1101101000, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 8'h55); lit("d21_2a", 10'b1010100101, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 8'h55); lit("d21_2b", 10'b1010100101, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 8'hD5); lit("d21_6",  10'b1010100110, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 8'($urandom)); lit("t_even", 10'b1011101000, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 8'($urandom)); lit("r_odd",  10'b1110101000, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 8'($urandom)); lit("k_after1", 10'b0011111010, 1'b1, 1'b1);

        // Start on odd slot, one error cycle, /T/ odd, TX_EN ignored during /R/
        drive(1'b1, 1'b0, 8'h11); lit("i2_drop", 10'b1001000101, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 8'h55); lit("s_start", 10'b1101101000, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 8'h55); lit("d_pre_v", 10'b1010100101, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 8'h55); lit("v_err",   10'b0111101000, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 8'h55); lit("d_post_v", 10'b1010100101, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 8'h55); lit("d_even",  10'b1010100101, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 8'h55); lit("t_odd",   10'b1011101000, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 8'h33); lit("r1_even", 10'b1110101000, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 8'h33); lit("r2_odd",  10'b1110101000, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 8'h33); lit("k_after2", 10'b0011111010, 1'b1, 1'b1);

        // Packet ending with positive disparity, idle resumes with /I1/
        drive(1'b0, 1'b0, 8'h00); lit("i2_b", 10'b1001000101, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 8'h77); lit("s_b",  10'b1101101000, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 8'h03); lit("d3_0", 10'b1100011011, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 8'h00); lit("t_pos", 10'b0100010111, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 8'h00); lit("r_pos", 10'b0001010111, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 8'h00); lit("k_pos", 10'b1100000101, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 8'h00); lit("i1",    10'b1010010110, 1'b0, 1'b0);

        // Reset in the middle of a packet
        drive(1'b1, 1'b0, 8'h55); lit("s_c", 10'b1101101000, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 8'h55);
        #2 Reset = 1'b0;
        @(negedge Clk); lit("mid_reset", 10'b0000000000, 1'b0, 1'b0);
        TX_EN = 1'b0;
        @(negedge Clk); lit("mid_reset2", 10'b0000000000, 1'b0, 1'b0);
        #2 Reset = 1'b1;
        drive(1'b0, 1'b0, 8'h55); lit("post_reset", 10'b0011111010, 1'b1, 1'b1);

        // Randomized traffic with occasional reset pulses
        en = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 7) == 0) en = ~en;
            if ($urandom_range(0, 499) == 0) begin
                #2 Reset = 1'b0;
                @(negedge Clk);
                #2 Reset = 1'b1;
            end
            drive(en, ($urandom_range(0, 9) == 0), 8'($urandom));
        end

        @(posedge Clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/pcs_transmit.md
PCS_TRANSMIT -- requirements
Module: pcs_transmit

Interface
REQ-001 Clk  input  1  transmit clock; all state changes on rising edge.
REQ-002 Reset  input  1  reset, asynchronous, active-low.
REQ-003 TX_EN  input  1  GMII transmit enable, sampled each rising Clk edge.
REQ-004 TX_ER  input  1  GMII transmit error, sampled each rising Clk edge.
REQ-005 TXD  input  8  GMII transmit octet.
REQ-006 tx_code_group  output  10  registered 8b/10b code-group to PMA.
- Bit order: {a,b,c,d,e,i,f,g,h,j}; bit 9 is transmitted first.
REQ-007 tx_even  output  1  high when tx_code_group occupies an even slot.
REQ-008 tx_rd  output  1  running disparity after the current tx_code_group (1 = positive).

Function
REQ-009 Each cycle SHALL emit exactly one code-group; latency from a sampled input to its tx_code_group is 1 cycle.
REQ-010 tx_even SHALL toggle every cycle; the first code-group after reset release SHALL be in an even slot (tx_even=1).
REQ-011 Encoding SHALL follow IEEE 802.3 Clause 36 8b/10b tables, including the D.x.A7 alternate rule.
REQ-012 Running disparity SHALL update after each code-group per the Clause 36 sub-block rules.
REQ-013 State machine SHALL have exactly these states: IDLE, START, DATA, END_T, END_R1, END_R2.
REQ-014 IDLE, even slot: emit K28.5.
REQ-015 IDLE, odd slot: emit D5.6 (/I1/) if disparity was positive before the K28.5, else D16.2 (/I2/); the idle pair always ends with negative disparity.
REQ-016 IDLE with TX_EN=1 on an even slot: emit /S/ (K27.7) in place of that octet; go to DATA.
REQ-017 IDLE with TX_EN=1 on an odd slot: complete the idle pair and discard that octet; go to START.
REQ-018 START: emit /S/ in the even slot, replacing the current octet; go to DATA.
REQ-019 DATA with TX_EN=1, TX_ER=0: emit Dx.y of TXD.
REQ-020 DATA with TX_EN=1, TX_ER=1: emit /V/ (K30.7).
REQ-021 DATA with TX_EN=0: emit /T/ (K29.7); go to END_R1.
REQ-022 END_R1: emit /R/ (K23.7).
- If this /R/ is in an even slot: go to END_R2.
- Else: go to IDLE.
REQ-023 END_R2: emit /R/; go to IDLE.
- Result: idle always resumes on an even slot.
REQ-024 TX_EN=1 sampled in END_T, END_R1 or END_R2 SHALL be ignored and those octets discarded.
- A new packet starts only through IDLE (REQ-016/017).
REQ-025 TX_ER with TX_EN=0 SHALL be ignored; carrier extension is not supported.
REQ-026 TXD is don't-care outside DATA and never alters IDLE/END code-groups.

Reset
REQ-027 Reset low SHALL immediately set:
- tx_code_group=10'b0000000000, tx_even=0, tx_rd=0;
- internal disparity negative; state IDLE.
REQ-028 Reset asserted mid-packet SHALL abort the packet with no /T/ or /R/ emitted.
- After release, output restarts with K28.5 RD- (0011111010), tx_even=1.
REQ-029 No output SHALL depend on a value sampled before reset release.

Verification
REQ-030 Reset release, TX_EN=0 -> repeating 0011111010 (tx_even=1), 1001000101 (tx_even=0); tx_rd alternates 1,0.
REQ-031 TX_EN rises on even slot, TXD=55,55,D5 -> 1101101000 (/S/ RD-), then D21.2, D21.2, D21.6 encodings.
REQ-032 TX_EN rises on odd slot -> 1001000101 (idle completes, octet dropped), next cycle 1101101000 (/S/) with tx_even=1.
REQ-033 TX_EN falls with /T/ in odd slot -> /T/, /R/ (even), /R/ (odd), then K28.5 on even.
- Falls with /T/ in even slot -> /T/, /R/, then K28.5 immediately.
REQ-034 TX_ER=1 for one DATA cycle -> K30.7 in that slot, surrounding octets encoded normally.
- After a positive-disparity end, idle is 1100000101 then 1010010110 (/I1/).
REQ-035 Reset pulsed during DATA -> all outputs zero during reset; first post-release group 0011111010, tx_even=1.
